alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 16-bit registered ALU (add/sub/or/and/xor/not/shl/shr, 1-cycle registered output with carry) between NUM_REQ requesters. It accepts one operation at a time, issues it to the ALU with a single-cycle enable, and captures the result and carry. It returns them to the granted requester through a valid/ready response, tagged with the requester index. The block sits between client engines and the ALU instance, which lives at the same level of hierarchy.

---
 rtl/alu_pkg.sv | 13 +
 rtl/ALU_16_bit.sv | 37 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/alu_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, datapath width and scheduler FSM encoding
package alu_pkg;
    localparam int DATA_W = 16;
    localparam logic [2:0] OP_ADD      = 3'd0;
    localparam logic [2:0] OP_SUB      = 3'd1;
    localparam logic [2:0] OP_OR       = 3'd2;
    localparam logic [2:0] OP_AND      = 3'd3;
    localparam logic [2:0] OP_XOR      = 3'd4;
    localparam logic [2:0] OP_NOT      = 3'd5;
    localparam logic [2:0] SHIFT_LEFT  = 3'd6;
    localparam logic [2:0] SHIFT_RIGHT = 3'd7;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/ALU_16_bit.sv
// ALU_16_bit: 16-bit ALU with registered result and carry, updated only on enable
module ALU_16_bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              cout
);
    logic [DATA_W:0]   res_d;
    logic [DATA_W-1:0] result_q;
    logic              cout_q;
    // SUB is a + ~b + 1, so its carry is the inverted borrow
    always_comb
        res_d = (opcode == OP_ADD)     ? {1'b0, a} + {1'b0, b} :
                (opcode == OP_SUB)     ? {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1) :
                (opcode == OP_OR)      ? {1'b0, a | b} :
                (opcode == OP_AND)     ? {1'b0, a & b} :
                (opcode == OP_XOR)     ? {1'b0, a ^ b} :
                (opcode == OP_NOT)     ? {1'b0, ~a} :
                (opcode == SHIFT_LEFT) ? {1'b0, a << 1} :
                                         {1'b0, a >> 1};
    always_ff @(posedge clk)
        if (rst) begin
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (enable) begin
            result_q <= res_d[DATA_W-1:0];
            cout_q   <= res_d[DATA_W];
        end
    assign result = result_q;
    assign cout   = cout_q;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin winner search starting at ptr, wrapping at NUM_REQ-1 to 0
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);
    logic [ID_W-1:0] idx;
    // Scan farthest-from-ptr first so the nearest requester overwrites last and wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k >= NUM_REQ) ? ID_W'(int'(ptr) + k - NUM_REQ) : ID_W'(int'(ptr) + k);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one registered 16-bit ALU between NUM_REQ requesters
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_cout,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_opcode,
    output logic                      alu_enable,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_cout,
    output logic                      busy
);
    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, rsp_id_q, rsp_id_d, grant_id;
    logic [NUM_REQ-1:0]  grant;
    logic                any_req;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d, win_a, win_b;
    logic [2:0]          alu_opcode_q, alu_opcode_d, win_op;
    logic                alu_enable_q, alu_enable_d, rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                win_op = req_opcode[3*i +: 3];
                win_a  = req_a[DATA_W*i +: DATA_W];
                win_b  = req_b[DATA_W*i +: DATA_W];
            end
    end

    // Operand registers hold outside an accept so the ALU inputs stay stable through ISSUE
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rsp_id_d     = rsp_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_enable_d = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        case (state_q)
            IDLE:
                if (any_req) begin
                    alu_a_d      = win_a;
                    alu_b_d      = win_b;
                    alu_opcode_d = win_op;
                    rsp_id_d     = grant_id;
                    ptr_d        = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    alu_enable_d = 1'b1;
                    state_d      = ISSUE;
                end
            ISSUE:
                state_d = CAPTURE;
            CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_cout_d   = alu_cout;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP:
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rsp_id_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rsp_id_q     <= rsp_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_enable_q <= alu_enable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
        end

    assign req_ready  = (state_q == IDLE) ? grant : '0;
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_enable = alu_enable_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed tests of the scheduler wired to ALU_16_bit, checked against a latency-level model
module tb_alu_rr_scheduler;
    import alu_pkg::*;
    localparam int NUM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM-1:0]    req_valid = '0;
    logic [NUM-1:0]    req_ready;
    logic [3*NUM-1:0]  req_opcode = '0;
    logic [16*NUM-1:0] req_a = '0;
    logic [16*NUM-1:0] req_b = '0;
    logic              rsp_valid, rsp_cout, alu_enable, alu_cout, busy;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]        alu_opcode;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(NUM), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_cout(alu_cout), .busy(busy)
    );

    ALU_16_bit u_alu (
        .clk(clk), .rst(rst), .enable(alu_enable), .a(alu_a), .b(alu_b),
        .opcode(alu_opcode), .result(alu_result), .cout(alu_cout)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_alu(logic [2:0] op, logic [15:0] a, logic [15:0] b);
        case (op)
            OP_ADD:     return 17'(int'(a) + int'(b));
            OP_SUB:     return {a >= b, a - b};
            OP_OR:      return {1'b0, a | b};
            OP_AND:     return {1'b0, a & b};
            OP_XOR:     return {1'b0, a ^ b};
            OP_NOT:     return {1'b0, ~a};
            SHIFT_LEFT: return {1'b0, a[14:0], 1'b0};
            default:    return {2'b00, a[15:1]};
        endcase
    endfunction

    // Model: phase counts cycles since accept (0 = free, 1 = enable, 2 = ALU busy, 3 = response)
    int          m_ph = 0, m_ptr = 0, m_id = 0;
    logic [15:0] m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]  m_op = '0;
    logic        m_c = 1'b0;

    function automatic int winner();
        int idx;
        for (int k = 0; k < NUM; k++) begin
            idx = (m_ptr + k) % NUM;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    initial forever begin
        int w;
        logic [16:0] r;
        @(negedge clk);
        w = winner();
        chk("req_ready", 32'(req_ready), (m_ph == 0 && w >= 0) ? (32'(1) << w) : 32'(0));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("alu_enable", 32'(alu_enable), 32'(m_ph == 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 3));
        chk("alu_ops", 32'({alu_opcode, alu_a}), 32'({m_op, m_a}));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("rsp_fields", 32'({rsp_id, rsp_cout, rsp_result}), 32'({2'(m_id), m_c, m_res}));
        if (rst) begin
            m_ph = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_c = 1'b0;
        end else if (m_ph == 0) begin
            if (w >= 0) begin
                m_id  = w;
                m_op  = req_opcode[3*w +: 3];
                m_a   = req_a[16*w +: 16];
                m_b   = req_b[16*w +: 16];
                m_ptr = (w + 1) % NUM;
                m_ph  = 1;
            end
        end else if (m_ph == 1) m_ph = 2;
        else if (m_ph == 2) begin
            r = ref_alu(m_op, m_a, m_b);
            m_res = r[15:0];
            m_c   = r[16];
            m_ph  = 3;
        end else if (rsp_ready) m_ph = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int r, logic [2:0] op, logic [15:0] a, logic [15:0] b);
        req_opcode[3*r +: 3] = op;
        req_a[16*r +: 16]    = a;
        req_b[16*r +: 16]    = b;
        req_valid[r]         = 1'b1;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 20 && g < 0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NUM; i++) if (req_ready[i]) g = i;
        end
    endtask

    task automatic wait_rsp(string nm, int id, logic [15:0] er, logic ec);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(rsp_valid), 32'(1));
        chk({nm, "_id"}, 32'(rsp_id), 32'(id));
        chk({nm, "_result"}, 32'(rsp_result), 32'(er));
        chk({nm, "_cout"}, 32'(rsp_cout), 32'(ec));
    endtask

    task automatic run_one(int r, logic [2:0] op, logic [15:0] a, logic [15:0] b,
                           logic [15:0] er, logic ec, string nm);
        int g;
        set_req(r, op, a, b);
        wait_grant(g);
        chk({nm, "_grant"}, 32'(g), 32'(r));
        tick();
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk({nm, "_en_issue"}, 32'(alu_enable), 32'(1));
        @(negedge clk);
        chk({nm, "_en_capture"}, 32'({alu_enable, rsp_valid}), 32'(0));
        @(negedge clk);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(1));
        chk({nm, "_id"}, 32'(rsp_id), 32'(r));
        chk({nm, "_result"}, 32'(rsp_result), 32'(er));
        chk({nm, "_cout"}, 32'(rsp_cout), 32'(ec));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int          exp_id[5]  = '{0, 1, 2, 3, 0};
        logic [15:0] exp_res[5] = '{16'h0FFF, 16'h0000, 16'h0FFF, 16'h01E0, 16'h0FFF};
        tick();
        tick();
        @(negedge clk);
        chk("reset_outputs", 32'({rsp_valid, alu_enable, busy, rsp_id, rsp_cout, rsp_result, alu_opcode}), 32'(0));
        chk("reset_alu_ab", {alu_a, alu_b}, 32'(0));
        tick();
        rst = 1'b0;

        run_one(1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "t1_add");
        run_one(0, OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, "t2_sub_pos");
        run_one(0, OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, "t2_sub_neg");
        run_one(1, OP_NOT, 16'h0F0F, 16'h1234, 16'hF0F0, 1'b0, "t2_not");

        rst = 1'b1;
        set_req(0, OP_XOR, 16'h00F0, 16'h0F0F);
        set_req(1, OP_AND, 16'h00F0, 16'h0F0F);
        set_req(2, OP_OR, 16'h00F0, 16'h0F0F);
        set_req(3, SHIFT_LEFT, 16'h00F0, 16'h0F0F);
        tick();
        tick();
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_grant(g);
            chk("t3_grant", 32'(g), 32'(exp_id[j]));
            tick();
            if (j == 4) req_valid = '0;
            wait_rsp("t3_rsp", exp_id[j], exp_res[j], 1'b0);
            tick();
        end

        rsp_ready = 1'b0;
        set_req(0, OP_AND, 16'hFFFF, 16'h00FF);
        set_req(2, OP_ADD, 16'h1234, 16'h1111);
        wait_grant(g);
        chk("t4_grant", 32'(g), 32'(2));
        tick();
        req_valid[2] = 1'b0;
        wait_rsp("t4_rsp", 2, 16'h2345, 1'b0);
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("t4_hold", 32'({rsp_valid, busy, req_ready, rsp_result}), 32'({1'b1, 1'b1, 4'b0000, 16'h2345}));
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_still_resp", 32'(rsp_valid), 32'(1));
        tick();
        @(negedge clk);
        chk("t4_idle", 32'({busy, req_ready}), 32'({1'b0, 4'b0001}));
        tick();
        req_valid[0] = 1'b0;
        wait_rsp("t4_rsp0", 0, 16'h00FF, 1'b0);
        tick();

        set_req(2, OP_XOR, 16'hAAAA, 16'h5555);
        wait_grant(g);
        chk("t5_grant", 32'(g), 32'(2));
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_reset", 32'({rsp_valid, alu_enable, busy, rsp_id, rsp_cout, rsp_result, alu_opcode}), 32'(0));
        chk("t5_reset_ab", {alu_a, alu_b}, 32'(0));
        tick();
        set_req(3, OP_OR, 16'h0001, 16'h0002);
        set_req(2, OP_AND, 16'h0003, 16'h0002);
        set_req(0, OP_ADD, 16'h7FFF, 16'h0001);
        wait_grant(g);
        chk("t5_ptr0", 32'(g), 32'(0));
        tick();
        req_valid = '0;
        wait_rsp("t5_rsp", 0, 16'h8000, 1'b0);
        tick();

        run_one(2, OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, "t6_setup");
        set_req(2, OP_SUB, 16'h0000, 16'h0001);
        set_req(3, SHIFT_RIGHT, 16'h8001, 16'h0000);
        wait_grant(g);
        chk("t6_first", 32'(g), 32'(3));
        tick();
        req_valid[3] = 1'b0;
        wait_rsp("t6_rsp3", 3, 16'h4000, 1'b0);
        tick();
        wait_grant(g);
        chk("t6_second", 32'(g), 32'(2));
        tick();
        req_valid[2] = 1'b0;
        wait_rsp("t6_rsp2", 2, 16'hFFFF, 1'b0);
        tick();

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
